// File: rtl/axil_slv_regfile.sv
// axil_slv_regfile: AXI4-Lite slave register file, DEPTH x 32-bit words.
// Rev 1.0 - independent read/write FSMs, byte strobes, SLVERR on out-of-range.
`default_nettype none

module axil_slv_regfile #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,

  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,

  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,

  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,

  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int              IDX_W       = ADDR_W - 2;
  localparam logic [IDX_W:0]  DEPTH_V     = (IDX_W + 1)'(DEPTH);
  localparam logic [1:0]      RESP_OKAY   = 2'b00;
  localparam logic [1:0]      RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [31:0] mem [DEPTH];

  // Ready outputs stay low until the first edge after reset release.
  logic init_done;

  wstate_t          w_state, w_next;
  logic             aw_done, w_done;
  logic [IDX_W-1:0] aw_idx_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_hs, w_hs, commit;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;
  logic             wr_in_range;

  rstate_t          r_state, r_next;
  logic             ar_hs;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [31:0]      rd_word;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // ---------------------------------------------------------------- write path
  assign s_axi_awready = init_done && (w_state == W_IDLE) && !aw_done;
  assign s_axi_wready  = init_done && (w_state == W_IDLE) && !w_done;
  assign s_axi_bvalid  = (w_state == W_RESP);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;

  assign wr_idx      = aw_done ? aw_idx_q : s_axi_awaddr[ADDR_W-1:2];
  assign wr_data     = w_done  ? wdata_q  : s_axi_wdata;
  assign wr_strb     = w_done  ? wstrb_q  : s_axi_wstrb;
  assign wr_in_range = {1'b0, wr_idx} < DEPTH_V;

  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if ((aw_hs || aw_done) && (w_hs || w_done)) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_done   <= 1'b0;
      w_state     <= W_IDLE;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      s_axi_bresp <= RESP_OKAY;
    end else begin
      init_done <= 1'b1;
      w_state   <= w_next;
      if (commit) begin
        aw_done     <= 1'b0;
        w_done      <= 1'b0;
        s_axi_bresp <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_done  <= 1'b1;
          aw_idx_q <= s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
          w_done  <= 1'b1;
          wdata_q <= s_axi_wdata;
          wstrb_q <= s_axi_wstrb;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (commit && wr_in_range) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) mem[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // ----------------------------------------------------------------- read path
  assign s_axi_arready = init_done && (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);

  assign ar_hs       = s_axi_arvalid && s_axi_arready;
  assign rd_idx      = s_axi_araddr[ADDR_W-1:2];
  assign rd_in_range = {1'b0, rd_idx} < DEPTH_V;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_idx == IDX_W'(i)) rd_word = mem[i];
    end
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // mem is sampled before any same-edge commit lands, so a colliding read sees old data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= R_IDLE;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        s_axi_rdata <= rd_in_range ? rd_word : 32'h0;
        s_axi_rresp <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

`default_nettype wire
